// File: rtl/sc_act_sequencer.sv
// Job sequencer for an FSM-based stochastic activation core: turns a binary operand into
// an LFSR bitstream, clears and warms the core, then counts its output ones over a fixed window.
module sc_act_sequencer #(
    parameter int W        = 8,
    parameter int LEN_LOG2 = 8,
    parameter int WARMUP   = 16,
    parameter int SEED     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                abort,
    output logic                core_reset,
    output logic                core_x,
    input  logic                core_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_LOG2:0]   out_data,
    output logic                busy
);
    localparam int PW = (LEN_LOG2 > 8) ? LEN_LOG2 : 8;
    localparam logic [PW-1:0] RUN_LAST  = PW'((64'd1 << LEN_LOG2) - 64'd1);
    localparam logic [PW-1:0] WARM_LAST = PW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [W-1:0]  SEED_V    = (W'(SEED) == '0) ? W'(1) : W'(SEED);
    // Maximal-length Fibonacci tap masks (bit n-1 set for tap n).
    localparam logic [W-1:0]  TAPS = (W == 8)  ? W'(32'h00B8) :
                                     (W == 10) ? W'(32'h0240) :
                                     (W == 12) ? W'(32'h0829) :
                                                 W'(32'hD008);

    typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [PW-1:0]      phase;
    logic [W-1:0]       lfsr, opnd, lfsr_nx;
    logic [LEN_LOG2:0]  acc;
    logic               core_reset_q;
    logic               streaming;

    assign lfsr_nx    = {lfsr[W-2:0], ^(lfsr & TAPS)};
    assign streaming  = (state == WARM) || (state == RUN);
    assign core_x     = streaming && (lfsr < opnd);
    assign core_reset = core_reset_q;
    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_data   = (state == DONE) ? acc : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_valid) state_nx = CLEAR;
            CLEAR: state_nx = abort ? IDLE : ((WARMUP > 0) ? WARM : RUN);
            WARM: begin
                if (abort)                   state_nx = IDLE;
                else if (phase == WARM_LAST) state_nx = RUN;
            end
            RUN: begin
                if (abort)                  state_nx = IDLE;
                else if (phase == RUN_LAST) state_nx = DONE;
            end
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= '0;
            lfsr         <= SEED_V;
            opnd         <= '0;
            acc          <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state        <= state_nx;
            // Registered so the core sees a glitch-free reset exactly for the CLEAR cycle.
            core_reset_q <= (state_nx == CLEAR);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd <= in_data;
                        lfsr <= SEED_V;
                    end
                end
                CLEAR: begin
                    phase <= '0;
                    if (abort) acc <= '0;
                end
                WARM, RUN: begin
                    lfsr  <= lfsr_nx;
                    phase <= (state_nx == state) ? phase + 1'b1 : '0;
                    if (abort)
                        acc <= '0;
                    else if (state == RUN)
                        acc <= acc + (LEN_LOG2 + 1)'(core_y);
                end
                DONE: begin
                    if (out_ready) acc <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
